// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM encoding (2-bit).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2,
    ST_ERR     = 2'd3
  } arb_state_t;

  // Encoding of the last-served requester.
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

  // Data side wins when it is the only eligible requester, or when both are
  // eligible and fetch was served last (alternating priority on contention).
  function automatic logic pick_dm(input logic if_elig,
                                   input logic dm_elig,
                                   input logic last_grant);
    return dm_elig & (~if_elig | (last_grant == GNT_IF));
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: counts cycles while enabled, flags the cycle in which
// the count would reach TIMEOUT so the owner can leave for its error state.
module arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);

  // Count enabled cycles; clear has priority, and the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count: this enabled cycle is the TIMEOUT-th without a clear.
  assign tc = en & (count == LIMIT_M1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the
// load/store path. Requests are latched at grant, the memory completes with a
// variable-latency ack, and a watchdog traps a memory that never answers.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_t       state;
  logic             last_grant;
  logic             if_elig;
  logic             dm_elig;
  logic             grant_dm;
  logic             busy;
  logic             wd_en;
  logic             wd_clr;
  logic             wd_tc;
  logic             wd_expired;
  logic [CNT_W-1:0] wd_count;

  // A request seen together with its own ack is the tail of the finished
  // transaction, not a new one.
  assign if_elig  = if_req_i & ~if_ack_o;
  assign dm_elig  = dm_req_i & ~dm_ack_o;
  assign grant_dm = pick_dm(if_elig, dm_elig, last_grant);

  assign busy   = (state == ST_BUSY_IF) || (state == ST_BUSY_DM);
  assign wd_en  = busy & ~mem_ack_i;
  assign wd_clr = ~wd_en;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clr   (wd_clr),
    .en    (wd_en),
    .count (wd_count),
    .tc    (wd_tc)
  );

  // Also trips if the count is ever found parked at the limit while busy.
  assign wd_expired = wd_tc | (wd_en & (wd_count == CNT_W'(TIMEOUT)));

  // Arbiter FSM with all handshake, memory-port and data outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      last_grant  <= GNT_IF;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_data_o   <= '0;
      dm_rdata_o  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_elig || dm_elig) begin
            mem_en_o <= 1'b1;
            if (grant_dm) begin
              mem_addr_o  <= dm_addr_i;
              mem_we_o    <= dm_we_i;
              mem_wdata_o <= dm_wdata_i;
              last_grant  <= GNT_DM;
              state       <= ST_BUSY_DM;
            end else begin
              mem_addr_o <= if_addr_i;
              mem_we_o   <= 1'b0;
              last_grant <= GNT_IF;
              state      <= ST_BUSY_IF;
            end
          end
        end
        ST_BUSY_IF, ST_BUSY_DM: begin
          if (mem_ack_i) begin
            if (state == ST_BUSY_IF) begin
              if_data_o <= mem_rdata_i;
              if_ack_o  <= 1'b1;
            end else begin
              // Stores leave the last load result untouched.
              if (!mem_we_o) begin
                dm_rdata_o <= mem_rdata_i;
              end
              dm_ack_o <= 1'b1;
            end
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            state    <= ST_IDLE;
          end else if (wd_expired) begin
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            err_o    <= 1'b1;
            state    <= ST_ERR;
          end
        end
        ST_ERR: begin
          // Trapped until reset; memory acks are ignored here.
          err_o <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Freeze the pipeline while any request is waiting or after a memory hang.
  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o) | err_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized requester/memory run checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [DW-1:0] RD_A = 32'h1357_9BDF;
  localparam logic [DW-1:0] RD_B = 32'h2468_ACE0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          wd_mem_ack = 1'b0;

  logic          if_ack, dm_ack, mem_en, mem_we, stall, err;
  logic [DW-1:0] if_data, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          wd_if_ack, wd_dm_ack, wd_mem_en, wd_mem_we, wd_stall, wd_err;
  logic [DW-1:0] wd_if_data, wd_dm_rdata, wd_mem_wdata;
  logic [AW-1:0] wd_mem_addr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .stall_o(stall), .err_o(err)
  );

  // Short-timeout instance sharing the requester inputs, with its own memory ack.
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .CNT_W(3)) dut_wd (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(wd_if_ack), .if_data_o(wd_if_data),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(wd_dm_ack), .dm_rdata_o(wd_dm_rdata),
    .mem_en_o(wd_mem_en), .mem_we_o(wd_mem_we), .mem_addr_o(wd_mem_addr),
    .mem_wdata_o(wd_mem_wdata),
    .mem_ack_i(wd_mem_ack), .mem_rdata_i(mem_rdata),
    .stall_o(wd_stall), .err_o(wd_err)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    mem_ack = 1'b0; wd_mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if ({if_ack, dm_ack, mem_en, mem_we, stall, err} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b, expected 000000", {if_ack, dm_ack, mem_en, mem_we, stall, err}); end
    n_vec++; if ({if_data, dm_rdata, mem_addr, mem_wdata} !== 128'b0) begin n_bad++; $display("FAIL reset_data: got %h, expected 0", {if_data, dm_rdata, mem_addr, mem_wdata}); end
    n_vec++; if ({wd_err, wd_mem_en} !== 2'b0) begin n_bad++; $display("FAIL reset_wd: got %b, expected 00", {wd_err, wd_mem_en}); end
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFACE_0001;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if ({if_ack, dm_ack, mem_en} !== 3'b0) begin n_bad++; $display("FAIL idle_ack_ignored: got %b, expected 000", {if_ack, dm_ack, mem_en}); end
    n_vec++; if (if_data !== 32'h0) begin n_bad++; $display("FAIL idle_ack_data: got %h, expected 0", if_data); end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    n_vec++; if ({mem_en, mem_we, stall, if_ack} !== 4'b1010) begin n_bad++; $display("FAIL fetch_grant: got %b, expected 1010", {mem_en, mem_we, stall, if_ack}); end
    n_vec++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL fetch_addr: got %h, expected 10", mem_addr); end
    @(negedge clk);
    n_vec++; if ({mem_en, if_ack, stall} !== 3'b101) begin n_bad++; $display("FAIL fetch_wait: got %b, expected 101", {mem_en, if_ack, stall}); end
    mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_vec++; if ({if_ack, mem_en, stall} !== 3'b100) begin n_bad++; $display("FAIL fetch_ack: got %b, expected 100", {if_ack, mem_en, stall}); end
    n_vec++; if (if_data !== 32'h8C22_0004) begin n_bad++; $display("FAIL fetch_data: got %h, expected 8c220004", if_data); end
    if_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({if_ack, mem_en} !== 2'b0) begin n_bad++; $display("FAIL fetch_pulse: got %b, expected 00", {if_ack, mem_en}); end
    n_vec++; if (if_data !== 32'h8C22_0004) begin n_bad++; $display("FAIL fetch_hold: got %h, expected 8c220004", if_data); end
  endtask

  task automatic test_both();
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    @(negedge clk);
    n_vec++; if ({mem_en, mem_we} !== 2'b10) begin n_bad++; $display("FAIL both_first_en: got %b, expected 10", {mem_en, mem_we}); end
    n_vec++; if (mem_addr !== 32'h44) begin n_bad++; $display("FAIL both_dm_first: got %h, expected 44", mem_addr); end
    mem_ack = 1'b1; mem_rdata = RD_A;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if ({dm_ack, if_ack, mem_en} !== 3'b100) begin n_bad++; $display("FAIL both_dm_ack_gap: got %b, expected 100", {dm_ack, if_ack, mem_en}); end
    n_vec++; if (dm_rdata !== RD_A) begin n_bad++; $display("FAIL both_dm_data: got %h, expected %h", dm_rdata, RD_A); end
    dm_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({mem_en, mem_addr} !== {1'b1, 32'h40}) begin n_bad++; $display("FAIL both_if_second: got %b/%h, expected 1/40", mem_en, mem_addr); end
    mem_ack = 1'b1; mem_rdata = RD_B;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if ({if_ack, dm_ack, if_data} !== {2'b10, RD_B}) begin n_bad++; $display("FAIL both_if_ack: got %b/%h, expected 10/%h", {if_ack, dm_ack}, if_data, RD_B); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_vec++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL store_grant: got %b/%h/%h, expected 11/20/deadbeef", {mem_en, mem_we}, mem_addr, mem_wdata); end
    dm_addr = 32'hFFFF_FFFC; dm_wdata = 32'h1234_5678;
    @(negedge clk);
    n_vec++; if ({mem_addr, mem_wdata} !== {32'h20, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL store_latched: got %h/%h, expected 20/deadbeef", mem_addr, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if ({dm_ack, mem_en, mem_we} !== 3'b100) begin n_bad++; $display("FAIL store_ack: got %b, expected 100", {dm_ack, mem_en, mem_we}); end
    n_vec++; if (dm_rdata !== RD_A) begin n_bad++; $display("FAIL store_rdata_kept: got %h, expected %h", dm_rdata, RD_A); end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency5();
    if_req = 1'b1; if_addr = 32'h30;
    @(negedge clk);
    n_vec++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL lat_en: got %b, expected 1", mem_en); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_vec++; if ({mem_en, if_ack, err} !== 3'b100) begin n_bad++; $display("FAIL lat_wait%0d: got %b, expected 100", i, {mem_en, if_ack, err}); end
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if ({if_ack, err, if_data} !== {2'b10, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL lat_ack: got %b/%h, expected 10/0badf00d", {if_ack, err}, if_data); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    if_req = 1'b1; if_addr = 32'h50;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_vec++; if ({wd_mem_en, wd_err} !== 2'b10) begin n_bad++; $display("FAIL wd_busy%0d: got %b, expected 10", i, {wd_mem_en, wd_err}); end
    end
    @(negedge clk);
    n_vec++; if ({wd_err, wd_mem_en, wd_stall, wd_if_ack} !== 4'b1010) begin n_bad++; $display("FAIL wd_err: got %b, expected 1010", {wd_err, wd_mem_en, wd_stall, wd_if_ack}); end
    n_vec++; if ({wd_dm_ack, wd_mem_we, wd_mem_addr, wd_mem_wdata} !== {2'b00, 32'h50, 32'h0}) begin n_bad++; $display("FAIL wd_err_regs: got %b/%h/%h, expected 00/50/0", {wd_dm_ack, wd_mem_we}, wd_mem_addr, wd_mem_wdata); end
    wd_mem_ack = 1'b1; mem_rdata = 32'hCAFE_CAFE; if_req = 1'b0;
    @(negedge clk);
    wd_mem_ack = 1'b0;
    n_vec++; if ({wd_if_ack, wd_err, wd_stall, wd_mem_en} !== 4'b0110) begin n_bad++; $display("FAIL wd_ack_ignored: got %b, expected 0110", {wd_if_ack, wd_err, wd_stall, wd_mem_en}); end
    n_vec++; if ({wd_if_data, wd_dm_rdata} !== 64'h0) begin n_bad++; $display("FAIL wd_data_kept: got %h/%h, expected 0/0", wd_if_data, wd_dm_rdata); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({wd_err, wd_mem_en, wd_stall} !== 3'b000) begin n_bad++; $display("FAIL wd_reset_clear: got %b, expected 000", {wd_err, wd_mem_en, wd_stall}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60;
    @(negedge clk);
    n_vec++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL midrst_busy: got %b, expected 1", mem_en); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({mem_en, dm_ack, mem_addr} !== {2'b00, 32'h0}) begin n_bad++; $display("FAIL midrst_async: got %b/%h, expected 00/0", {mem_en, dm_ack}, mem_addr); end
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h7777_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if ({dm_ack, mem_en, dm_rdata} !== {2'b00, 32'h0}) begin n_bad++; $display("FAIL midrst_ack_ignored: got %b/%h, expected 00/0", {dm_ack, mem_en}, dm_rdata); end
  endtask

  // Random traffic: the bench plays both requesters and the memory, and a
  // transaction-level model predicts grant order, acks, data and stall.
  task automatic test_random();
    logic          ifp = 1'b0, dmp = 1'b0, if_linger = 1'b0, dm_linger = 1'b0;
    logic [AW-1:0] if_a = '0, dm_a = '0, cur_addr = '0;
    logic          dm_w = 1'b0, cur_we = 1'b0;
    logic [DW-1:0] dm_d = '0, cur_wdata = '0, rdata_sent = '0;
    logic [DW-1:0] exp_if_data = '0, exp_dm_rdata = '0;
    logic          busy = 1'b0, ack_driven = 1'b0, owner = 1'b0, last_g = 1'b0;
    logic          elig_if = 1'b0, elig_dm = 1'b0, exp_ack_if, exp_ack_dm, exp_stall;
    int            wait_cnt = 0;
    do_reset();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      exp_ack_if = ack_driven && (owner == 1'b0);
      exp_ack_dm = ack_driven && (owner == 1'b1);
      if (exp_ack_if) exp_if_data = rdata_sent;
      if (exp_ack_dm && !cur_we) exp_dm_rdata = rdata_sent;
      exp_stall = (if_req && !exp_ack_if) || (dm_req && !exp_ack_dm);
      n_vec++; if ({if_ack, dm_ack} !== {exp_ack_if, exp_ack_dm}) begin n_bad++; $display("FAIL rnd_acks cyc %0d: got %b, expected %b", cyc, {if_ack, dm_ack}, {exp_ack_if, exp_ack_dm}); end
      n_vec++; if ({if_data, dm_rdata} !== {exp_if_data, exp_dm_rdata}) begin n_bad++; $display("FAIL rnd_data cyc %0d: got %h/%h, expected %h/%h", cyc, if_data, dm_rdata, exp_if_data, exp_dm_rdata); end
      n_vec++; if ({stall, err} !== {exp_stall, 1'b0}) begin n_bad++; $display("FAIL rnd_stall cyc %0d: got %b, expected %b", cyc, {stall, err}, {exp_stall, 1'b0}); end
      if (ack_driven) begin
        busy = 1'b0;
        n_vec++; if ({mem_en, mem_we} !== 2'b00) begin n_bad++; $display("FAIL rnd_release cyc %0d: got %b, expected 00", cyc, {mem_en, mem_we}); end
      end else if (busy) begin
        n_vec++; if ({mem_en, mem_we, mem_addr} !== {1'b1, cur_we, cur_addr}) begin n_bad++; $display("FAIL rnd_hold cyc %0d: got %b/%h, expected %b/%h", cyc, {mem_en, mem_we}, mem_addr, {1'b1, cur_we}, cur_addr); end
      end else if (elig_if || elig_dm) begin
        owner = (elig_if && elig_dm) ? ~last_g : elig_dm;
        last_g = owner;
        busy = 1'b1;
        cur_addr = owner ? dm_a : if_a;
        cur_we = owner & dm_w;
        cur_wdata = dm_d;
        wait_cnt = $urandom_range(0, 4);
        n_vec++; if ({mem_en, mem_we, mem_addr} !== {1'b1, cur_we, cur_addr}) begin n_bad++; $display("FAIL rnd_grant cyc %0d: got %b/%h, expected %b/%h", cyc, {mem_en, mem_we}, mem_addr, {1'b1, cur_we}, cur_addr); end
        if (cur_we) begin
          n_vec++; if (mem_wdata !== cur_wdata) begin n_bad++; $display("FAIL rnd_wdata cyc %0d: got %h, expected %h", cyc, mem_wdata, cur_wdata); end
        end
      end else begin
        n_vec++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rnd_idle cyc %0d: got %b, expected 0", cyc, mem_en); end
      end
      // Memory side: answer after the chosen latency; stray acks while idle.
      ack_driven = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (busy) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          rdata_sent = mem_rdata;
          ack_driven = 1'b1;
        end else begin
          wait_cnt--;
        end
      end else begin
        mem_ack = ($urandom_range(0, 7) == 0);
      end
      // Requesters: finish on ack (sometimes holding req one more edge),
      // otherwise maybe start a new request.
      if (exp_ack_if) begin
        ifp = 1'b0; if_linger = 1'($urandom_range(0, 1));
      end else begin
        if_linger = 1'b0;
        if (!ifp && cyc < 600 && $urandom_range(0, 2) == 0) begin
          ifp = 1'b1; if_a = $urandom;
        end
      end
      if (exp_ack_dm) begin
        dmp = 1'b0; dm_linger = 1'($urandom_range(0, 1));
      end else begin
        dm_linger = 1'b0;
        if (!dmp && cyc < 600 && $urandom_range(0, 2) == 0) begin
          dmp = 1'b1; dm_a = $urandom; dm_w = 1'($urandom_range(0, 1)); dm_d = $urandom;
        end
      end
      if_req = ifp | if_linger; if_addr = if_a;
      dm_req = dmp | dm_linger; dm_addr = dm_a; dm_we = dm_w; dm_wdata = dm_d;
      elig_if = ifp;
      elig_dm = dmp;
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_both();
    test_store();
    test_latency5();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch path and the load/store data path.
- Each requester uses a req/ack handshake. The memory side uses an enable/ack handshake with variable latency.
- Produces a stall for the PC/pipeline while any request is outstanding.
- Includes a watchdog that flags a memory that never acknowledges.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles in a busy state without mem_ack_i before error. Must be ≥1.
- CNT_W, 8, watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- if_req_i  input  1  fetch request, held high until if_ack_o.
- if_addr_i  input  ADDR_W  fetch address.
- if_ack_o  output  1  one-cycle completion pulse for fetch.
- if_data_o  output  DATA_W  fetched word, valid while if_ack_o=1, held afterwards.
- dm_req_i  input  1  data request, held high until dm_ack_o.
- dm_we_i  input  1  1 = store, 0 = load.
- dm_addr_i  input  ADDR_W  data address.
- dm_wdata_i  input  DATA_W  store data.
- dm_ack_o  output  1  one-cycle completion pulse for data.
- dm_rdata_o  output  DATA_W  load result, valid while dm_ack_o=1, held afterwards.
- mem_en_o  output  1  memory access active.
- mem_we_o  output  1  memory write strobe.
- mem_addr_o  output  ADDR_W  registered memory address.
- mem_wdata_o  output  DATA_W  registered store data.
- mem_ack_i  input  1  memory completion, single cycle.
- mem_rdata_i  input  DATA_W  read data, valid with mem_ack_i.
- stall_o  output  1  freeze PC/pipeline.
- err_o  output  1  sticky watchdog error.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; all outputs 0, including data/address registers; last_grant=IF; watchdog count=0.
  - A mem_ack_i arriving after reset is released is ignored while in IDLE.
- FSM states: IDLE, BUSY_IF, BUSY_DM, ERR.
- IDLE grant decision, evaluated each edge:
  - Eligible request = req high and that requester's ack_o not high this cycle. A req seen together with its ack is completion, not a new request.
  - Only dm eligible → BUSY_DM.
  - Only if eligible → BUSY_IF.
  - Both eligible → grant the one opposite to last_grant. Data wins when last_grant=IF.
  - On grant: latch address, we and wdata into mem_*_o; set mem_en_o=1; mem_we_o=dm_we_i for DM, 0 for IF; update last_grant.
- BUSY_x:
  - mem_en_o stays 1; the watchdog increments each cycle.
  - On mem_ack_i=1: capture mem_rdata_i into if_data_o (IF) or dm_rdata_o (DM load only; stores leave dm_rdata_o unchanged).
  - On that same edge: pulse x_ack_o=1 for exactly one cycle, drop mem_en_o/mem_we_o, clear the watchdog, return to IDLE.
- Latency:
  - Request sampled at edge N → mem_en_o high from cycle N+1.
  - mem_ack_i in cycle M → ack_o high in cycle M+1.
  - Minimum request-to-ack is 2 cycles.
  - Back-to-back: the other requester can be granted at edge M+1, i.e. mem_en_o is low for exactly one cycle between accesses.
- Watchdog: count reaching TIMEOUT in BUSY_x without ack → ERR.
- ERR:
  - err_o=1; mem_en_o=0; no acks issued; stall_o=1.
  - Left only by reset.
  - mem_ack_i is ignored.
- stall_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o) | err_o.
- Requester-side rules:
  - A requester dropping req before ack is illegal.
  - The arbiter keeps its latched transaction regardless and still pulses ack.
- Input changes while BUSY do not affect mem_addr_o or mem_wdata_o, which are registered at grant.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_BUSY_IF, ST_BUSY_DM, ST_ERR (2-bit);
  - grant constants GNT_IF=0, GNT_DM=1.
- One sub-module, arb_watchdog: clear/enable inputs, count output, terminal-count output at TIMEOUT; parameters TIMEOUT, CNT_W.

Test Plan:
- if_req_i=1, if_addr_i=0x0000_0010, mem_ack_i one cycle after mem_en_o with rdata 0x8C22_0004 → mem_addr_o=0x10; if_ack_o pulses 1 cycle; if_data_o=0x8C22_0004; stall_o high until the ack cycle.
- Both requests asserted in the same cycle after reset (last_grant=IF) → DM granted first. IF is granted one cycle after dm_ack_o. mem_en_o is low for exactly 1 cycle between the two accesses.
- Store dm_we_i=1, addr 0x20, wdata 0xDEAD_BEEF → mem_we_o=1, mem_wdata_o=0xDEAD_BEEF; dm_ack_o pulses; dm_rdata_o unchanged from its prior value.
- Memory latency 5 cycles (mem_ack_i 5 cycles after mem_en_o) → ack_o 6 cycles after mem_en_o rose; no early ack; watchdog does not fire.
- TIMEOUT=4, mem_ack_i never asserted → err_o=1 after 4 busy cycles; mem_en_o=0; stall_o=1; a later mem_ack_i is ignored; rst_i low clears to IDLE with err_o=0.
- rst_i pulsed low mid BUSY_DM → immediately mem_en_o=0, dm_ack_o=0; state IDLE; a subsequent mem_ack_i is ignored.
